// File: rtl/codes_pkg.sv
// Shared decode codes: immediate format enum, base opcodes and default widths.
package codes_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int WORD_WIDTH = 32;

  typedef enum logic [2:0] {
    FMT_R     = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_NONE  = 3'd7
  } imm_fmt_e;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  // SLLI/SRLI/SRAI share the OP-IMM opcodes; funct3 picks them out.
  function automatic logic is_shift(input logic [2:0] funct3);
    return (funct3 == 3'b001) || (funct3 == 3'b101);
  endfunction

endpackage

// File: rtl/imm_decode_comb.sv
// Combinational immediate decode: format class, immediate, illegal flag and PC-relative target.
module imm_decode_comb
  import codes_pkg::*;
#(
  parameter int XLEN = DATA_WIDTH
) (
  input  logic [WORD_WIDTH-1:0] instr,
  input  logic [XLEN-1:0]       pc,
  output logic [XLEN-1:0]       imm,
  output imm_fmt_e              fmt,
  output logic [XLEN-1:0]       target,
  output logic                  illegal
);

  logic [6:0]  opc;
  logic [2:0]  funct3;
  logic [11:0] i_imm;
  logic [11:0] s_imm;
  logic [12:0] b_imm;
  logic [31:0] u_imm;
  logic [20:0] j_imm;
  logic        pc_rel;

  assign opc    = instr[6:0];
  assign funct3 = instr[14:12];
  assign i_imm  = instr[31:20];
  assign s_imm  = {instr[31:25], instr[11:7]};
  assign b_imm  = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign u_imm  = {instr[31:12], 12'b0};
  assign j_imm  = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    imm     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    pc_rel  = 1'b0;
    case (opc)
      OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
        fmt = FMT_I;
        imm = XLEN'($signed(i_imm));
      end
      OPC_OP_IMM: begin
        if (is_shift(funct3)) begin
          fmt = FMT_SHAMT;
          imm = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
        end else begin
          fmt = FMT_I;
          imm = XLEN'($signed(i_imm));
        end
      end
      OPC_OP_IMM_32: begin
        // Word-sized ops only exist on RV64; the shamt is always 5 bits.
        if (XLEN == 64) begin
          if (is_shift(funct3)) begin
            fmt = FMT_SHAMT;
            imm = XLEN'(instr[24:20]);
          end else begin
            fmt = FMT_I;
            imm = XLEN'($signed(i_imm));
          end
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_STORE: begin
        fmt = FMT_S;
        imm = XLEN'($signed(s_imm));
      end
      OPC_BRANCH: begin
        fmt    = FMT_B;
        imm    = XLEN'($signed(b_imm));
        pc_rel = 1'b1;
      end
      OPC_LUI: begin
        fmt = FMT_U;
        imm = XLEN'($signed(u_imm));
      end
      OPC_AUIPC: begin
        fmt    = FMT_U;
        imm    = XLEN'($signed(u_imm));
        pc_rel = 1'b1;
      end
      OPC_JAL: begin
        fmt    = FMT_J;
        imm    = XLEN'($signed(j_imm));
        pc_rel = 1'b1;
      end
      OPC_OP: fmt = FMT_R;
      OPC_OP_32: begin
        if (XLEN == 64) fmt = FMT_R;
        else illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign target = pc + (pc_rel ? imm : XLEN'(4));

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate-generation stage: one-cycle latency, two-entry skid so back-pressure never drops an instruction.
// in_ready comes straight from the skid-occupancy flop, never from out_ready.
module imm_gen_pipe
  import codes_pkg::*;
#(
  parameter int XLEN = DATA_WIDTH,
  parameter int ILEN = WORD_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ILEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output imm_fmt_e        out_fmt,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    imm_fmt_e        fmt;
    logic [XLEN-1:0] target;
    logic            illegal;
    logic [XLEN-1:0] pc;
  } res_t;

  localparam res_t RES_RST = '{imm: '0, fmt: FMT_NONE, target: '0, illegal: 1'b0, pc: '0};

  res_t dec_res;
  res_t main_q, main_d;
  res_t skid_q, skid_d;
  logic main_vld_q, main_vld_d;
  logic skid_vld_q, skid_vld_d;
  logic accept;

  imm_decode_comb #(.XLEN(XLEN)) u_dec (
    .instr   (in_instr),
    .pc      (in_pc),
    .imm     (dec_res.imm),
    .fmt     (dec_res.fmt),
    .target  (dec_res.target),
    .illegal (dec_res.illegal)
  );
  assign dec_res.pc = in_pc;

  assign accept = in_valid && !skid_vld_q;

  // The skid can only be occupied while main is, so an empty main implies an empty skid.
  always_comb begin
    main_vld_d = main_vld_q;
    main_d     = main_q;
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (main_vld_q && !out_ready) begin
      if (accept) begin
        skid_vld_d = 1'b1;
        skid_d     = dec_res;
      end
    end else if (skid_vld_q) begin
      main_d     = skid_q;
      skid_vld_d = 1'b0;
    end else begin
      main_vld_d = accept;
      if (accept) main_d = dec_res;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_vld_q <= 1'b0;
      main_q     <= RES_RST;
      skid_vld_q <= 1'b0;
      skid_q     <= RES_RST;
    end else begin
      main_vld_q <= main_vld_d;
      main_q     <= main_d;
      skid_vld_q <= skid_vld_d;
      skid_q     <= skid_d;
    end
  end

  assign in_ready    = !skid_vld_q;
  assign out_valid   = main_vld_q;
  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_target  = main_q.target;
  assign out_illegal = main_q.illegal;
  assign out_pc      = main_q.pc;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: scoreboard-driven checks on an RV64 instance plus an RV32 instance for width-dependent decode.
module tb_imm_gen_pipe;
  import codes_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_instr;
  logic [63:0] in_pc, out_imm, out_target, out_pc;
  imm_fmt_e    out_fmt;

  logic        d32_in_valid, d32_in_ready, d32_out_valid, d32_out_illegal;
  logic [31:0] d32_in_instr, d32_in_pc, d32_out_imm, d32_out_target, d32_out_pc;
  imm_fmt_e    d32_out_fmt;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] imm;
    imm_fmt_e    fmt;
    logic [63:0] tgt;
    logic        ill;
  } vec_t;

  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  imm_gen_pipe #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
    .out_target(out_target), .out_illegal(out_illegal), .out_pc(out_pc)
  );

  imm_gen_pipe #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(d32_in_valid), .in_ready(d32_in_ready), .in_instr(d32_in_instr), .in_pc(d32_in_pc),
    .out_valid(d32_out_valid), .out_ready(1'b1), .out_imm(d32_out_imm), .out_fmt(d32_out_fmt),
    .out_target(d32_out_target), .out_illegal(d32_out_illegal), .out_pc(d32_out_pc)
  );

  initial forever #5 clk = ~clk;

  task automatic test_reset();
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_imm !== 64'd0 || out_target !== 64'd0 || out_pc !== 64'd0) begin
      errors++; $display("FAIL reset_data got imm %h tgt %h pc %h exp all 0", out_imm, out_target, out_pc); end
    checks++; if (out_fmt !== FMT_NONE) begin errors++; $display("FAIL reset_fmt got %0d exp %0d", out_fmt, FMT_NONE); end
    checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b exp 0", out_illegal); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Stream every vector back-to-back with out_ready=1: one result per cycle, one cycle late.
  task automatic test_formats();
    vec_t tab[10];
    vec_t e;
    tab[0] = '{32'h80040413, 64'h1000, 64'hFFFF_FFFF_FFFF_F800, FMT_I, 64'h1004, 1'b0};
    tab[1] = '{32'h00208463, 64'h2000, 64'h8, FMT_B, 64'h2008, 1'b0};
    tab[2] = '{32'h0080006F, 64'h3000, 64'h8, FMT_J, 64'h3008, 1'b0};
    tab[3] = '{32'h43F2D293, 64'h3100, 64'h3F, FMT_SHAMT, 64'h3104, 1'b0};
    tab[4] = '{32'h00001017, 64'hFFFF_FFFF_FFFF_F000, 64'h1000, FMT_U, 64'h0, 1'b0};
    tab[5] = '{32'h0000007F, 64'h3200, 64'h0, FMT_NONE, 64'h3204, 1'b1};
    tab[6] = '{32'hFE112E23, 64'h3300, 64'hFFFF_FFFF_FFFF_FFFC, FMT_S, 64'h3304, 1'b0};
    tab[7] = '{32'h800000B7, 64'h3400, 64'hFFFF_FFFF_8000_0000, FMT_U, 64'h3404, 1'b0};
    tab[8] = '{32'h002081B3, 64'h3500, 64'h0, FMT_R, 64'h3504, 1'b0};
    tab[9] = '{32'h4050D09B, 64'h3600, 64'h5, FMT_SHAMT, 64'h3604, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fmt%0d_valid got %b exp 1", i-1, out_valid); end
        e = sb.pop_front();
        checks++; if (out_imm !== e.imm) begin errors++; $display("FAIL fmt%0d_imm got %h exp %h", i-1, out_imm, e.imm); end
        checks++; if (out_fmt !== e.fmt) begin errors++; $display("FAIL fmt%0d_fmt got %0d exp %0d", i-1, out_fmt, e.fmt); end
        checks++; if (out_target !== e.tgt) begin errors++; $display("FAIL fmt%0d_target got %h exp %h", i-1, out_target, e.tgt); end
        checks++; if (out_illegal !== e.ill) begin errors++; $display("FAIL fmt%0d_illegal got %b exp %b", i-1, out_illegal, e.ill); end
        checks++; if (out_pc !== e.pc) begin errors++; $display("FAIL fmt%0d_pc got %h exp %h", i-1, out_pc, e.pc); end
      end
      if (i < 10) begin
        in_valid = 1'b1; in_instr = tab[i].instr; in_pc = tab[i].pc;
        sb.push_back(tab[i]);
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t a, b, c, e;
    bit   c_taken;
    int   n_out;
    a = '{32'h80040413, 64'h4000, 64'hFFFF_FFFF_FFFF_F800, FMT_I, 64'h4004, 1'b0};
    b = '{32'h00208463, 64'h4004, 64'h8, FMT_B, 64'h400C, 1'b0};
    c = '{32'h0080006F, 64'h4008, 64'h8, FMT_J, 64'h4010, 1'b0};
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = a.instr; in_pc = a.pc; sb.push_back(a);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_pc !== a.pc) begin errors++; $display("FAIL bp_a_main got v %b pc %h exp 1 %h", out_valid, out_pc, a.pc); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_one got %b exp 1", in_ready); end
    in_instr = b.instr; in_pc = b.pc; sb.push_back(b);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full got %b exp 0", in_ready); end
    checks++; if (out_pc !== a.pc) begin errors++; $display("FAIL bp_hold1 got pc %h exp %h", out_pc, a.pc); end
    in_instr = c.instr; in_pc = c.pc; sb.push_back(c);
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (out_valid !== 1'b1 || out_pc !== e.pc || out_imm !== e.imm || out_target !== e.tgt) begin
      errors++; $display("FAIL bp_hold2 got v %b pc %h imm %h tgt %h exp 1 %h %h %h", out_valid, out_pc, out_imm, out_target, e.pc, e.imm, e.tgt); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_held got %b exp 0", in_ready); end
    out_ready = 1'b1;
    c_taken = 1'b0;
    n_out = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (c_taken) in_valid = 1'b0;
      if (cyc == 0) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_rise got %b exp 1", in_ready); end
      end
      if (out_valid === 1'b1) begin
        n_out++;
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL bp_extra got pc %h exp no output", out_pc);
        end else begin
          e = sb.pop_front();
          if (out_pc !== e.pc || out_imm !== e.imm || out_target !== e.tgt || out_fmt !== e.fmt) begin
            errors++; $display("FAIL bp_order got pc %h imm %h tgt %h exp %h %h %h", out_pc, out_imm, out_target, e.pc, e.imm, e.tgt);
          end
        end
      end
      c_taken = in_valid && in_ready;
    end
    in_valid = 1'b0;
    checks++; if (n_out != 2 || sb.size() != 0) begin errors++; $display("FAIL bp_count got %0d left %0d exp 2 left 0", n_out, sb.size()); end
    sb.delete();
  endtask

  task automatic test_flush();
    bit seen;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h80040413; in_pc = 64'h5000;
    @(negedge clk);
    in_instr = 32'h00208463; in_pc = 64'h5004;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_pre_full got %b exp 0", in_ready); end
    in_instr = 32'h0080006F; in_pc = 64'h5008; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b exp 1", in_ready); end
    out_ready = 1'b1;
    seen = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL flush_ghost got output after flush exp none"); end
  endtask

  task automatic test_xlen32();
    @(negedge clk);
    d32_in_valid = 1'b1; d32_in_instr = 32'h43F2D293; d32_in_pc = 32'h100;
    @(negedge clk);
    d32_in_instr = 32'h0010809B; d32_in_pc = 32'h104;
    checks++; if (d32_out_valid !== 1'b1 || d32_out_imm !== 32'h1F) begin
      errors++; $display("FAIL x32_srai_imm got v %b imm %h exp 1 0000001f", d32_out_valid, d32_out_imm); end
    checks++; if (d32_out_fmt !== FMT_SHAMT || d32_out_target !== 32'h104) begin
      errors++; $display("FAIL x32_srai_fmt got %0d tgt %h exp %0d 00000104", d32_out_fmt, d32_out_target, FMT_SHAMT); end
    @(negedge clk);
    d32_in_valid = 1'b0;
    checks++; if (d32_out_illegal !== 1'b1 || d32_out_fmt !== FMT_NONE || d32_out_imm !== 32'h0) begin
      errors++; $display("FAIL x32_opimm32 got ill %b fmt %0d imm %h exp 1 %0d 0", d32_out_illegal, d32_out_fmt, d32_out_imm, FMT_NONE); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h80040413; in_pc = 64'h6000;
    @(negedge clk);
    in_instr = 32'h00208463; in_pc = 64'h6004;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL arst_pre got v %b rdy %b exp 1 0", out_valid, in_ready); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL arst_now got v %b rdy %b exp 0 1", out_valid, in_ready); end
    checks++; if (out_pc !== 64'd0 || out_fmt !== FMT_NONE) begin errors++; $display("FAIL arst_data got pc %h fmt %0d exp 0 %0d", out_pc, out_fmt, FMT_NONE); end
    #1 rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_after got %b exp 0", out_valid); end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_pc = '0;
    d32_in_valid = 1'b0; d32_in_instr = '0; d32_in_pc = '0;
    test_reset();
    test_formats();
    test_back_to_back();
    test_flush();
    test_xlen32();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
